// File: rtl/spi_master_if.sv
// spi_master_if
// Host-side handshake and SPI pin bundle for spi_master.
//
// Signals:
//   i_start       request a frame (honoured only while o_busy is low)
//   i_cmd         command field, latched at start
//   i_addr        LED address field, latched at start
//   i_payload     write payload field, latched at start
//   miso          serial data from the slave
//   sclk          SPI clock, idle low
//   cs            chip select, active low
//   mosi          serial data to the slave, MSB first
//   o_busy        high from accepted start until the end of the CS gap
//   o_done        one-cycle pulse at frame end
//   o_rx_payload  byte captured from miso during the last byte of the frame
//
// Modports:
//   master  the spi_master view (drives the SPI pins and status)
//   slave   the host/peripheral view (drives requests and miso)
interface spi_master_if #(
    parameter int CMD_BITS     = 8,
    parameter int ADDR_BITS    = 8,
    parameter int PAYLOAD_BITS = 8
);
    logic                    i_start;
    logic [CMD_BITS-1:0]     i_cmd;
    logic [ADDR_BITS-1:0]    i_addr;
    logic [PAYLOAD_BITS-1:0] i_payload;
    logic                    miso;
    logic                    sclk;
    logic                    cs;
    logic                    mosi;
    logic                    o_busy;
    logic                    o_done;
    logic [PAYLOAD_BITS-1:0] o_rx_payload;

    modport master (
        input  i_start, i_cmd, i_addr, i_payload, miso,
        output sclk, cs, mosi, o_busy, o_done, o_rx_payload
    );

    modport slave (
        output i_start, i_cmd, i_addr, i_payload, miso,
        input  sclk, cs, mosi, o_busy, o_done, o_rx_payload
    );
endinterface

// File: rtl/spi_master.sv
// spi_master
// SPI Mode 0 master for the LED control link. Sends one frame
// {cmd, addr, payload} MSB first on sclk/cs/mosi, preceded by one dummy
// SCLK period that the slave discards, and captures the byte the slave
// returns on miso during the last byte of the frame. SCLK is derived from
// sysclk by a divider; every SPI pin is driven straight from a flop.
//
// Parameters:
//   CLK_DIV       SCLK half-period in sysclk cycles (4..255)
//   CS_GAP        minimum cs-high cycles after a frame before o_busy drops (>=4)
//   CMD_BITS, ADDR_BITS, PAYLOAD_BITS  field widths (24-bit frame in total)
//
// Ports:
//   sysclk        system clock, all logic on its rising edge
//   rst_n         synchronous active-low reset
//   bus           spi_master_if.master (handshake, frame fields, SPI pins)
//
// Optional build macro SPI_MASTER_DEBUG_EN adds:
//   o_debug_stage    [2:0] current stage (IDLE=0 SETUP=1 SHIFT=2 HOLD=3 GAP=4)
//   o_bit_cnt_debug  [4:0] current SHIFT period, 0 outside SHIFT
module spi_master #(
    parameter int CLK_DIV      = 5,
    parameter int CS_GAP       = 4,
    parameter int CMD_BITS     = 8,
    parameter int ADDR_BITS    = 8,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic         sysclk,
    input  logic         rst_n,
    spi_master_if.master bus
`ifdef SPI_MASTER_DEBUG_EN
    ,
    output logic [2:0]   o_debug_stage,
    output logic [4:0]   o_bit_cnt_debug
`endif
);

    localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    // Period 0 is the dummy, so the last data bit travels in period FRAME_BITS.
    localparam int LAST_PERIOD = FRAME_BITS;
    // First period whose rising edge captures the returned byte.
    localparam int RX_FIRST = FRAME_BITS - PAYLOAD_BITS + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(CS_GAP);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]              state_r;
    logic [DIV_W-1:0]        div_cnt_r;
    logic [GAP_W-1:0]        gap_cnt_r;
    logic [4:0]              period_r;
    logic [FRAME_BITS-1:0]   frame_r;
    logic [PAYLOAD_BITS-1:0] rx_shift_r;
    logic [PAYLOAD_BITS-1:0] rx_payload_r;
    logic                    sclk_r;
    logic                    cs_r;
    logic                    mosi_r;
    logic                    busy_r;
    logic                    done_r;

    logic div_last_s;
    logic gap_last_s;
    logic period_last_s;
    logic rx_window_s;

    assign div_last_s    = (div_cnt_r == DIV_W'(CLK_DIV - 1));
    assign gap_last_s    = (gap_cnt_r == GAP_W'(CS_GAP - 1));
    assign period_last_s = (period_r == 5'(LAST_PERIOD));
    assign rx_window_s   = (period_r >= 5'(RX_FIRST));

    // Frame sequencer: divider, period counter, SPI pins and handshake.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= '0;
            gap_cnt_r    <= '0;
            period_r     <= 5'd0;
            frame_r      <= '0;
            rx_shift_r   <= '0;
            rx_payload_r <= '0;
            sclk_r       <= 1'b0;
            cs_r         <= 1'b1;
            mosi_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sclk_r    <= 1'b0;
                    div_cnt_r <= '0;
                    gap_cnt_r <= '0;
                    period_r  <= 5'd0;
                    if (bus.i_start) begin
                        frame_r    <= {bus.i_cmd, bus.i_addr, bus.i_payload};
                        rx_shift_r <= '0;
                        // Present the MSB during SETUP so it is stable long
                        // before the first rising edge.
                        mosi_r     <= bus.i_cmd[CMD_BITS-1];
                        cs_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SETUP;
                    end else begin
                        mosi_r <= 1'b0;
                        cs_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    if (div_last_s) begin
                        div_cnt_r <= '0;
                        period_r  <= 5'd0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end

                ST_SHIFT: begin
                    if (div_last_s) begin
                        div_cnt_r <= '0;
                        if (!sclk_r) begin
                            // Rising edge: capture miso only for the final byte.
                            sclk_r <= 1'b1;
                            if (rx_window_s) begin
                                rx_shift_r <= {rx_shift_r[PAYLOAD_BITS-2:0], bus.miso};
                            end else begin
                                rx_shift_r <= rx_shift_r;
                            end
                        end else begin
                            sclk_r <= 1'b0;
                            if (period_last_s) begin
                                // Clearing here keeps the period count at 0
                                // whenever the link is not shifting.
                                period_r <= 5'd0;
                                state_r  <= ST_HOLD;
                            end else begin
                                period_r <= period_r + 5'd1;
                                // The dummy period repeats the MSB, so nothing
                                // changes after period 0; after period p the
                                // next period carries bit FRAME_BITS-1-p.
                                if (period_r != 5'd0) begin
                                    mosi_r <= frame_r[5'(FRAME_BITS - 1) - period_r];
                                end else begin
                                    mosi_r <= mosi_r;
                                end
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (div_last_s) begin
                        div_cnt_r    <= '0;
                        gap_cnt_r    <= '0;
                        cs_r         <= 1'b1;
                        mosi_r       <= 1'b0;
                        done_r       <= 1'b1;
                        rx_payload_r <= rx_shift_r;
                        state_r      <= ST_GAP;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end

                ST_GAP: begin
                    if (gap_last_s) begin
                        gap_cnt_r <= '0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    sclk_r  <= 1'b0;
                    cs_r    <= 1'b1;
                    mosi_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sclk         = sclk_r;
    assign bus.cs           = cs_r;
    assign bus.mosi         = mosi_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_done       = done_r;
    assign bus.o_rx_payload = rx_payload_r;

`ifdef SPI_MASTER_DEBUG_EN
    // State encoding matches the debug stage numbering, and period_r is held
    // at 0 outside SHIFT, so both debug outputs come straight from flops.
    assign o_debug_stage   = state_r;
    assign o_bit_cnt_debug = period_r;
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master
// Directed and randomized checks of spi_master at CLK_DIV = 5, 4 and 17
// (CS_GAP = 4). A slave model per instance decodes mosi on sclk rising
// edges, returns a chosen byte in periods 17..24 and random noise before
// that, and measures SCLK phase widths, event times and mosi stability.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int CS_GAP = 4;
    localparam int NDUT   = 3;
    localparam logic [7:0] CMD_LED_SET  = 8'h01;
    localparam logic [7:0] CMD_LED_READ = 8'h02;

    logic            sysclk  = 1'b0;
    logic            rst_n   = 1'b0;
    logic [NDUT-1:0] start_v = '0;
    logic [7:0]      cmd     = 8'h00;
    logic [7:0]      addr    = 8'h00;
    logic [7:0]      payload = 8'h00;
    logic [7:0]      resp    = 8'h00;
    int              cyc     = 0;
    int              t0      = 0;
    int              vectors = 0;
    int              miscompares = 0;

    always #5 sysclk = ~sysclk;

    // Cycle label: value of cyc between edge k and edge k+1 is k.
    always @(posedge sysclk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int DIV = (gi == 0) ? 5 : ((gi == 1) ? 4 : 17);

        spi_master_if bus ();

        logic        miso_r = 1'b0;
        logic        prev_sclk = 1'b0;
        logic        prev_cs = 1'b1;
        logic        prev_mosi = 1'b0;
        logic        prev_busy = 1'b0;
        logic [24:0] mosi_bits = '0;
        logic [24:0] frame_at_done = '0;
        logic        done_cs = 1'b0;
        logic [7:0]  done_rx = 8'h00;
        int rise_n = 0, rises_at_done = 0, run_len = 0, lo_valid = 0;
        int cs_high_run = 0, last_gap = 0;
        int hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
        int done_n = 0, done_cyc = 0, cs_low_cyc = 0, first_rise_cyc = 0;
        int busy_fall_cyc = 0, bad_mosi = 0;

        assign bus.i_start   = start_v[gi];
        assign bus.i_cmd     = cmd;
        assign bus.i_addr    = addr;
        assign bus.i_payload = payload;
        assign bus.miso      = miso_r;

        spi_master #(.CLK_DIV(DIV), .CS_GAP(CS_GAP)) dut (
            .sysclk (sysclk),
            .rst_n  (rst_n),
            .bus    (bus)
        );

        // Slave model and line monitor, sampled mid-cycle.
        always @(negedge sysclk) begin
            if (!bus.cs && prev_cs) begin
                last_gap    = cs_high_run;
                cs_high_run = 0;
                rise_n      = 0;
                mosi_bits   = '0;
                lo_valid    = 0;
                run_len     = 1;
                hi_min = 100000; hi_max = 0; lo_min = 100000; lo_max = 0;
                cs_low_cyc  = cyc;
                miso_r      = 1'($urandom_range(0, 1));
            end else if (!bus.cs) begin
                if (bus.sclk && !prev_sclk) begin
                    if (lo_valid != 0) begin
                        if (run_len < lo_min) lo_min = run_len;
                        if (run_len > lo_max) lo_max = run_len;
                    end
                    rise_n    = rise_n + 1;
                    mosi_bits = {mosi_bits[23:0], bus.mosi};
                    if (rise_n == 1) first_rise_cyc = cyc;
                    run_len = 1;
                    // rise_n now names the period whose rising edge comes next.
                    if (rise_n >= 17 && rise_n <= 24) miso_r = resp[3'(24 - rise_n)];
                    else miso_r = 1'($urandom_range(0, 1));
                end else if (!bus.sclk && prev_sclk) begin
                    if (run_len < hi_min) hi_min = run_len;
                    if (run_len > hi_max) hi_max = run_len;
                    lo_valid = 1;
                    run_len  = 1;
                end else begin
                    run_len = run_len + 1;
                end
                if ((bus.mosi != prev_mosi) && !(prev_sclk && !bus.sclk)) bad_mosi = bad_mosi + 1;
            end else begin
                cs_high_run = cs_high_run + 1;
            end
            if (bus.o_done) begin
                done_n        = done_n + 1;
                done_cyc      = cyc;
                done_cs       = bus.cs;
                done_rx       = bus.o_rx_payload;
                frame_at_done = mosi_bits;
                rises_at_done = rise_n;
            end
            if (!bus.o_busy && prev_busy) busy_fall_cyc = cyc;
            prev_sclk = bus.sclk;
            prev_cs   = bus.cs;
            prev_mosi = bus.mosi;
            prev_busy = bus.o_busy;
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [NDUT-1:0] which, input logic [7:0] c,
                               input logic [7:0] a, input logic [7:0] p);
        cmd = c; addr = a; payload = p;
        start_v = which;
        t0 = cyc;
        tick();
        start_v = '0;
    endtask

    task automatic wait_done0(input int target, input int budget);
        int n;
        n = 0;
        while (g_dut[0].done_n < target && n < budget) begin
            tick();
            n++;
        end
        check("done_wait", (g_dut[0].done_n >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Reference: mosi stream is {F[23], F}, o_done at T+52*D+1, rx = returned byte.
    task automatic check_frame0(input string tag, input logic [23:0] f, input logic [7:0] rx_exp);
        check({tag, "_rises"}, g_dut[0].rises_at_done, 32'd25);
        check({tag, "_frame"}, {8'h00, g_dut[0].frame_at_done[23:0]}, {8'h00, f});
        check({tag, "_dummy"}, {31'd0, g_dut[0].frame_at_done[24]}, {31'd0, f[23]});
        check({tag, "_rx"}, {24'd0, g_dut[0].done_rx}, {24'd0, rx_exp});
        check({tag, "_done_t"}, g_dut[0].done_cyc - t0, 52 * 5 + 1);
        check({tag, "_cs_done"}, {31'd0, g_dut[0].done_cs}, 32'd1);
    endtask

    task automatic check_busy_fall0(input string tag);
        repeat (CS_GAP + 2) tick();
        check({tag, "_busy_t"}, g_dut[0].busy_fall_cyc - t0, 52 * 5 + 1 + CS_GAP);
        check({tag, "_busy"}, {31'd0, g_dut[0].bus.o_busy}, 32'd0);
    endtask

    initial begin
        logic [23:0] f;
        int dn;
        int wt;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_cs",   {31'd0, g_dut[0].bus.cs},   32'd1);
        check("rst_sclk", {31'd0, g_dut[0].bus.sclk}, 32'd0);
        check("rst_mosi", {31'd0, g_dut[0].bus.mosi}, 32'd0);
        check("rst_busy", {31'd0, g_dut[0].bus.o_busy}, 32'd0);
        check("rst_done", {31'd0, g_dut[0].bus.o_done}, 32'd0);
        check("rst_rx",   {24'd0, g_dut[0].bus.o_rx_payload}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Write frame on all three dividers at once
        resp = 8'h3C;
        f = {CMD_LED_SET, 8'h02, 8'h80};
        start_frame(3'b111, CMD_LED_SET, 8'h02, 8'h80);
        wait_done0(1, 400);
        check_frame0("wr", f, 8'h3C);
        check("wr_cs_low_t", g_dut[0].cs_low_cyc - t0, 32'd1);
        check("wr_rise_t", g_dut[0].first_rise_cyc - t0, 2 * 5 + 1);
        check("wr_hi5", g_dut[0].hi_min * 1000 + g_dut[0].hi_max, 5 * 1000 + 5);
        check("wr_lo5", g_dut[0].lo_min * 1000 + g_dut[0].lo_max, 5 * 1000 + 5);
        check_busy_fall0("wr");
        wt = 0;
        while (g_dut[2].done_n < 1 && wt < 1000) begin tick(); wt++; end
        check("d17_wait", (g_dut[2].done_n >= 1) ? 32'd1 : 32'd0, 32'd1);
        check("d4_done_t", g_dut[1].done_cyc - t0, 52 * 4 + 1);
        check("d17_done_t", g_dut[2].done_cyc - t0, 52 * 17 + 1);
        check("d4_hi", g_dut[1].hi_min * 1000 + g_dut[1].hi_max, 4 * 1000 + 4);
        check("d4_lo", g_dut[1].lo_min * 1000 + g_dut[1].lo_max, 4 * 1000 + 4);
        check("d17_hi", g_dut[2].hi_min * 1000 + g_dut[2].hi_max, 17 * 1000 + 17);
        check("d17_lo", g_dut[2].lo_min * 1000 + g_dut[2].lo_max, 17 * 1000 + 17);
        check("d4_frame", {8'h00, g_dut[1].frame_at_done[23:0]}, {8'h00, f});
        check("d17_frame", {8'h00, g_dut[2].frame_at_done[23:0]}, {8'h00, f});
        check("d4_rx", {24'd0, g_dut[1].done_rx}, 32'h3C);
        check("d17_rx", {24'd0, g_dut[2].done_rx}, 32'h3C);
        repeat (CS_GAP + 2) tick();

        // Read frame: returned 0xA5, noise on miso in periods 0..16
        resp = 8'hA5;
        f = {CMD_LED_READ, 8'h01, 8'h00};
        start_frame(3'b001, CMD_LED_READ, 8'h01, 8'h00);
        wait_done0(2, 400);
        check_frame0("rd", f, 8'hA5);
        check_busy_fall0("rd");

        // Start pulse in the middle of a frame is ignored
        resp = 8'h5A;
        f = {CMD_LED_SET, 8'h07, 8'h11};
        start_frame(3'b001, CMD_LED_SET, 8'h07, 8'h11);
        while (cyc < t0 + 100) tick();
        start_v = 3'b001;
        tick();
        start_v = '0;
        wait_done0(3, 400);
        check_frame0("ign", f, 8'h5A);
        while (cyc < t0 + 270) tick();
        check("ign_busy_t", g_dut[0].busy_fall_cyc - t0, 52 * 5 + 1 + CS_GAP);
        check("ign_no_second", g_dut[0].done_n, 32'd3);
        check("ign_cs_idle", {31'd0, g_dut[0].bus.cs}, 32'd1);

        // Reset in the middle of a frame aborts it
        resp = 8'hC3;
        start_frame(3'b001, CMD_LED_READ, 8'h03, 8'h00);
        while (cyc < t0 + 120) tick();
        rst_n = 1'b0;
        tick();
        check("mrst_cs",   {31'd0, g_dut[0].bus.cs},   32'd1);
        check("mrst_sclk", {31'd0, g_dut[0].bus.sclk}, 32'd0);
        check("mrst_busy", {31'd0, g_dut[0].bus.o_busy}, 32'd0);
        check("mrst_rx",   {24'd0, g_dut[0].bus.o_rx_payload}, 32'd0);
        rst_n = 1'b1;
        dn = g_dut[0].done_n;
        repeat (300) tick();
        check("mrst_no_done", g_dut[0].done_n, dn);
        f = {CMD_LED_READ, 8'h04, 8'h00};
        start_frame(3'b001, CMD_LED_READ, 8'h04, 8'h00);
        wait_done0(dn + 1, 400);
        check_frame0("post", f, 8'hC3);
        check_busy_fall0("post");

        // Start held high: two back-to-back frames
        resp = 8'h96;
        f = {CMD_LED_SET, 8'h05, 8'h42};
        cmd = CMD_LED_SET; addr = 8'h05; payload = 8'h42;
        start_v = 3'b001;
        t0 = cyc;
        dn = g_dut[0].done_n;
        wait_done0(dn + 1, 400);
        check_frame0("b2b1", f, 8'h96);
        wt = g_dut[0].done_cyc;
        resp = 8'h69;
        cmd = CMD_LED_READ; addr = 8'h06; payload = 8'h00;
        f = {CMD_LED_READ, 8'h06, 8'h00};
        wait_done0(dn + 2, 400);
        start_v = '0;
        check("b2b_period", g_dut[0].done_cyc - wt, 52 * 5 + 1 + CS_GAP);
        check("b2b_gap", g_dut[0].last_gap, CS_GAP + 1);
        check("b2b2_frame", {8'h00, g_dut[0].frame_at_done[23:0]}, {8'h00, f});
        check("b2b2_rx", {24'd0, g_dut[0].done_rx}, 32'h69);
        repeat (CS_GAP + 3) tick();
        check("b2b_stop", {31'd0, g_dut[0].bus.o_busy}, 32'd0);

        // Randomized frames
        for (int k = 0; k < 4; k++) begin
            logic [7:0] rc, ra, rp;
            rc = 8'($urandom); ra = 8'($urandom); rp = 8'($urandom);
            resp = 8'($urandom);
            f = {rc, ra, rp};
            dn = g_dut[0].done_n;
            start_frame(3'b001, rc, ra, rp);
            wait_done0(dn + 1, 400);
            check_frame0("rnd", f, resp);
            check_busy_fall0("rnd");
        end

        check("mosi_stable0", g_dut[0].bad_mosi, 32'd0);
        check("mosi_stable4", g_dut[1].bad_mosi, 32'd0);
        check("mosi_stable17", g_dut[2].bad_mosi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
